// File: rtl/video_stream_source.sv
// Programmable raster source: vs/hs/de timing plus Y/U/V test patterns.
// Timing fields and pattern are shadowed per frame so the host can retime between frames.
module video_stream_source #(
    parameter int H_WIDTH    = 12,
    parameter int V_WIDTH    = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [H_WIDTH-1:0]    i_h_sync,
    input  logic [H_WIDTH-1:0]    i_h_bp,
    input  logic [H_WIDTH-1:0]    i_h_active,
    input  logic [H_WIDTH-1:0]    i_h_fp,
    input  logic [V_WIDTH-1:0]    i_v_sync,
    input  logic [V_WIDTH-1:0]    i_v_bp,
    input  logic [V_WIDTH-1:0]    i_v_active,
    input  logic [V_WIDTH-1:0]    i_v_fp,
    input  logic [1:0]            i_pattern,
    output logic                  o_vs,
    output logic                  o_hs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic [DATA_WIDTH-1:0] o_u,
    output logic [DATA_WIDTH-1:0] o_v,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int HC = H_WIDTH + 2;
    localparam int VC = V_WIDTH + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [H_WIDTH-1:0] H_ONE    = 1;
    localparam logic [V_WIDTH-1:0] V_ONE    = 1;
    localparam logic [HC-1:0]      HC_ONE   = 1;
    localparam logic [HC-1:0]      HC_EIGHT = 8;
    localparam logic [VC-1:0]      VC_ONE   = 1;

    typedef struct packed {
        logic [H_WIDTH-1:0] hs;
        logic [H_WIDTH-1:0] hbp;
        logic [H_WIDTH-1:0] ha;
        logic [H_WIDTH-1:0] hfp;
        logic [V_WIDTH-1:0] vs;
        logic [V_WIDTH-1:0] vbp;
        logic [V_WIDTH-1:0] va;
        logic [V_WIDTH-1:0] vfp;
        logic [1:0]         pat;
    } shadow_t;

    function automatic logic [H_WIDTH-1:0] clamp_h(input logic [H_WIDTH-1:0] f);
        return (f == '0) ? H_ONE : f;
    endfunction

    function automatic logic [V_WIDTH-1:0] clamp_v(input logic [V_WIDTH-1:0] f);
        return (f == '0) ? V_ONE : f;
    endfunction

    logic [1:0]            state_q, state_d;
    logic                  start_q, stop_q;
    logic [HC-1:0]         h_cnt_q, h_cnt_d;
    logic [VC-1:0]         v_cnt_q, v_cnt_d;
    shadow_t               sh_q, sh_d;
    logic [2:0]            bar_q, bar_d;
    logic [HC-1:0]         acc_q, acc_d;
    logic                  vs_q, vs_d, hs_q, hs_d, de_q, de_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] y_q, y_d, u_q, u_d, v_q, v_d;

    logic [HC-1:0] h_act_start, h_act_end, h_last, acc_n;
    logic [VC-1:0] v_act_start, v_act_end, v_last;
    logic          running, h_wrap, frame_wrap, capture, clear;
    logic          h_in, v_in, de_now, y_b3;
    logic [7:0]    x_lo, y8, u8, v8;
    logic [2:0]    bar_n;

    always_comb begin
        h_act_start = HC'(sh_q.hs) + HC'(sh_q.hbp);
        h_act_end   = h_act_start + HC'(sh_q.ha);
        h_last      = h_act_end + HC'(sh_q.hfp) - HC_ONE;
        v_act_start = VC'(sh_q.vs) + VC'(sh_q.vbp);
        v_act_end   = v_act_start + VC'(sh_q.va);
        v_last      = v_act_end + VC'(sh_q.vfp) - VC_ONE;

        running    = (state_q != S_IDLE);
        h_wrap     = (h_cnt_q == h_last);
        frame_wrap = h_wrap && (v_cnt_q == v_last);

        state_d = state_q;
        capture = running && frame_wrap;
        clear   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_RUN;
                    capture = 1'b1;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (start_q) state_d = S_RUN;
                else if (frame_wrap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        sh_d = sh_q;
        if (capture) begin
            sh_d = '{hs: clamp_h(i_h_sync), hbp: clamp_h(i_h_bp),
                     ha: clamp_h(i_h_active), hfp: clamp_h(i_h_fp),
                     vs: clamp_v(i_v_sync), vbp: clamp_v(i_v_bp),
                     va: clamp_v(i_v_active), vfp: clamp_v(i_v_fp),
                     pat: i_pattern};
        end

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clear) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (running) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = frame_wrap ? '0 : v_cnt_q + VC_ONE;
            end else begin
                h_cnt_d = h_cnt_q + HC_ONE;
            end
        end

        h_in   = (h_cnt_q >= h_act_start) && (h_cnt_q < h_act_end);
        v_in   = (v_cnt_q >= v_act_start) && (v_cnt_q < v_act_end);
        de_now = running && h_in && v_in;
        x_lo   = 8'(h_cnt_q - h_act_start);
        y_b3   = 1'((v_cnt_q - v_act_start) >> 3);

        // acc holds x*8 - bar*h_active; narrow lines may cross several bars per pixel
        acc_n = '0;
        bar_n = '0;
        bar_d = '0;
        acc_d = '0;
        if (running && h_in) begin
            acc_n = acc_q + HC_EIGHT;
            bar_n = bar_q;
            for (int i = 0; i < 8; i++) begin
                if (acc_n >= HC'(sh_q.ha)) begin
                    acc_n = acc_n - HC'(sh_q.ha);
                    bar_n = bar_n + 3'd1;
                end
            end
            acc_d = acc_n;
            bar_d = bar_n;
        end

        y8 = 8'd0;
        u8 = 8'd0;
        v8 = 8'd0;
        if (de_now) begin
            case (sh_q.pat)
                2'd0: begin
                    y8 = 8'd16 + {bar_q, 5'b0};
                    u8 = 8'd128 - {2'b0, bar_q, 3'b0};
                    v8 = 8'd128 + {2'b0, bar_q, 3'b0};
                end
                2'd1: begin
                    y8 = x_lo;
                    u8 = 8'd128;
                    v8 = 8'd128;
                end
                2'd2: begin
                    y8 = (x_lo[3] ^ y_b3) ? 8'd235 : 8'd16;
                    u8 = 8'd128;
                    v8 = 8'd128;
                end
                default: begin
                    y8 = 8'd128;
                    u8 = 8'd128;
                    v8 = 8'd128;
                end
            endcase
        end

        hs_d   = running && (h_cnt_q < HC'(sh_q.hs));
        vs_d   = running && (v_cnt_q < VC'(sh_q.vs));
        de_d   = de_now;
        done_d = running && frame_wrap;
        busy_d = running;
        y_d    = DATA_WIDTH'(y8) << (DATA_WIDTH - 8);
        u_d    = DATA_WIDTH'(u8) << (DATA_WIDTH - 8);
        v_d    = DATA_WIDTH'(v8) << (DATA_WIDTH - 8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            sh_q    <= '0;
            bar_q   <= '0;
            acc_q   <= '0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            start_q <= i_start;
            stop_q  <= i_stop;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            sh_q    <= sh_d;
            bar_q   <= bar_d;
            acc_q   <= acc_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            de_q    <= de_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
        end
    end

    assign o_vs         = vs_q;
    assign o_hs         = hs_q;
    assign o_de         = de_q;
    assign o_y          = y_q;
    assign o_u          = u_q;
    assign o_v          = v_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule
